// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and defaults for the load/store unit.
// The optional bus timeout is enabled by defining LSU_TIMEOUT_EN.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes/replication and load lane select/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_offset,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [3:0]  st_wstrb,
    output logic [31:0] st_wdata_rep,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;

    always_comb begin
        st_wstrb     = 4'b1111;
        st_wdata_rep = st_wdata;
        case (st_size)
            SZ_BYTE: begin
                st_wstrb     = 4'b0001 << st_offset;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_wstrb     = 4'b0011 << st_offset;
                st_wdata_rep = {2{st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend.
    assign ld_shifted = ld_word >> {ld_offset, 3'b000};

    always_comb begin
        ld_data = ld_word;
        case (ld_size)
            SZ_BYTE: ld_data = ld_unsigned ? {24'h0, ld_shifted[7:0]}
                                           : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            SZ_HALF: ld_data = ld_unsigned ? {16'h0, ld_shifted[15:0]}
                                           : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_dmem.sv
// Load/store unit between the pipeline and a single-word data memory port.
// Define LSU_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES without mem_ack.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for a request; illegal/misaligned ones rejected
// ST_BUSY | mem_req held with stable mem_* until mem_ack (or timeout)
// ST_DONE | one cycle; rdata_valid for loads, pipeline released
module lsu_dmem
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        dmem_rw,
    input  logic [1:0]  access_size,
    input  logic        UnsignedSel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        misaligned,
    output logic        bus_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state, state_nx;
    logic        req_bad, accept, ack_hit, timeout_hit;
    logic [1:0]  ld_size_q, ld_off_q;
    logic        ld_uns_q, is_load_q;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata_rep, ld_data;

    assign req_bad = is_misaligned(access_size, addr[1:0]);
    assign accept  = (state == ST_IDLE) && req_valid && !req_bad;
    assign ack_hit = (state == ST_BUSY) && mem_ack;

    lsu_align u_align (
        .st_size     (access_size),
        .st_offset   (addr[1:0]),
        .st_wdata    (wdata),
        .ld_size     (ld_size_q),
        .ld_offset   (ld_off_q),
        .ld_unsigned (ld_uns_q),
        .ld_word     (mem_rdata),
        .st_wstrb    (st_wstrb),
        .st_wdata_rep(st_wdata_rep),
        .ld_data     (ld_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (accept) begin
            to_cnt <= '0;
        end else if ((state == ST_BUSY) && !mem_ack) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Fires in the TIMEOUT_CYCLES-th ack-less BUSY cycle; a same-cycle ack wins.
    assign timeout_hit = (state == ST_BUSY) && !mem_ack &&
                         (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign bus_error   = timeout_hit;
    assign stall       = accept || (state == ST_BUSY);
    assign rdata_valid = (state == ST_DONE) && is_load_q;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = ST_BUSY;
            ST_BUSY: begin
                if (ack_hit)          state_nx = ST_DONE;
                else if (timeout_hit) state_nx = ST_IDLE;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
            misaligned <= 1'b0;
            ld_size_q  <= SZ_BYTE;
            ld_off_q   <= 2'b00;
            ld_uns_q   <= 1'b0;
            is_load_q  <= 1'b0;
        end else begin
            state      <= state_nx;
            misaligned <= (state == ST_IDLE) && req_valid && req_bad;
            if (accept) begin
                mem_req   <= 1'b1;
                mem_we    <= dmem_rw;
                mem_addr  <= {addr[31:2], 2'b00};
                mem_wstrb <= dmem_rw ? st_wstrb : 4'b0000;
                mem_wdata <= dmem_rw ? st_wdata_rep : 32'h0;
                ld_size_q <= access_size;
                ld_off_q  <= addr[1:0];
                ld_uns_q  <= UnsignedSel;
                is_load_q <= !dmem_rw;
            end else if (ack_hit || timeout_hit) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
            if (ack_hit && is_load_q) begin
                rdata <= ld_data;
            end
        end
    end

endmodule
